// File: rtl/serial_cell_sequencer.sv
// serial_cell_sequencer: serial unsigned A > B comparator built from one reusable comparison cell
//   Operands are walked MSB-first, one bit per clock, through a single "greater / still equal" cell.
//   Ports:
//     clk    in   system clock, rising edge
//     rst    in   synchronous active-high reset
//     start  in   begin a comparison (honoured only when idle)
//     a, b   in   WIDTH-bit operands, captured on the accepting edge
//     busy   out  high whenever the sequencer is not idle
//     done   out  one-cycle pulse; f is valid from this cycle
//     f      out  registered result A > B, held until the next done
//     f_mid  out  running "still equal" cell flag, for debug
//   Build option: define SERIAL_CELL_EARLY_EXIT_EN to leave SHIFT at the first differing bit.
module serial_cell_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             f,
    output logic             f_mid
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, FINAL} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt_q;
    logic             eq_q, gt_q, done_q, f_q;
    logic             diff, eq_d, gt_d, exit_d;
    always_comb begin
        diff = a_q[cnt_q] ^ b_q[cnt_q];
        // once a difference has been seen the decision is frozen
        eq_d = eq_q ? ~diff : 1'b0;
        gt_d = eq_q ? (a_q[cnt_q] & ~b_q[cnt_q]) : gt_q;
    end
`ifdef SERIAL_CELL_EARLY_EXIT_EN
    assign exit_d = (cnt_q == '0) || (eq_q && diff);
`else
    assign exit_d = (cnt_q == '0);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            done_q  <= 1'b0;
            f_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    cnt_q   <= CW'(WIDTH - 1);
                    eq_q    <= 1'b1;
                    gt_q    <= 1'b0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    eq_q <= eq_d;
                    gt_q <= gt_d;
                    if (exit_d) state_q <= FINAL;
                    else cnt_q <= cnt_q - 1'b1;
                end
                FINAL: begin
                    f_q     <= gt_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign f     = f_q;
    assign f_mid = eq_q;
endmodule

// File: tb/tb_serial_cell_sequencer.sv
// tb_serial_cell_sequencer: directed self-checking bench for serial_cell_sequencer at WIDTH=8
module tb_serial_cell_sequencer;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, f, f_mid;
    int         total = 0, bad = 0;
`ifdef SERIAL_CELL_EARLY_EXIT_EN
    localparam int LAT_MSB = 2;
`else
    localparam int LAT_MSB = 9;
`endif
    serial_cell_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .f(f), .f_mid(f_mid)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input int exp_f, input int exp_eq, input int exp_lat);
        int n;
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a = ~av;
        b = ~bv;
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_f"}, f, exp_f);
        chk({tag, "_fmid"}, f_mid, exp_eq);
        chk({tag, "_idle"}, busy, 0);
        step();
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_hold"}, f, exp_f);
    endtask
    initial begin
        int dones, at, fv, last;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_f", f, 0);
        chk("rst_fmid", f_mid, 1);
        rst = 1'b0;
        step();
        run_op("a5_5a", 8'hA5, 8'h5A, 1, 0, LAT_MSB);
        run_op("eq_3c", 8'h3C, 8'h3C, 0, 1, 9);
        run_op("lsb_80_81", 8'h80, 8'h81, 0, 0, 9);
`ifndef SERIAL_CELL_EARLY_EXIT_EN
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        dones = 0;
        at = 0;
        fv = 0;
        for (int n = 1; n <= 12; n++) begin
            if (n == 3) begin start = 1'b1; a = 8'h00; b = 8'hFF; end
            if (n == 4) start = 1'b0;
            if (n == 5) begin start = 1'b1; a = 8'h00; b = 8'h01; end
            if (n == 6) start = 1'b0;
            step();
            if (done) begin dones++; at = n; fv = f; end
        end
        chk("ign_dones", dones, 1);
        chk("ign_at", at, 9);
        chk("ign_f", fv, 1);
`endif
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_f", f, 0);
        chk("abort_done", done, 0);
        chk("abort_fmid", f_mid, 1);
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (done) dones++;
        end
        chk("abort_nodone", dones, 0);
        run_op("post_abort", 8'h01, 8'h00, 1, 0, 9);
        a = 8'h01;
        b = 8'h00;
        start = 1'b1;
        step();
        dones = 0;
        last = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            chk("cont_busy", busy, !done);
            if (done) begin
                dones++;
                chk("cont_gap", n - last, 10);
                chk("cont_f", f, 1);
                last = n;
            end
        end
        chk("cont_dones", dones, 4);
        start = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_cell_sequencer.md
Name: serial_cell_sequencer

Overview:
- Controller that time-multiplexes one left-to-right iterative comparison cell over an N-bit operand pair.
- Serializes operands MSB-first, one bit per clock, into a registered cell state (f_mid), then applies the final-cell mapping to produce f.
- Result: f = 1 iff A > B (unsigned).
- Replaces the unrolled initial/middle/final cell chain with a start/busy/done-sequenced single-cell datapath.

Parameters:
- WIDTH, 8, operand width in bits (legal range 1 to 32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to begin a comparison; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while state is not IDLE (decoded from state).
- done  output  1  registered one-cycle pulse; f is valid from this cycle.
- f  output  1  registered result, A > B; held until the next done.
- f_mid  output  1  current cell "still equal" flag (eq_mid), exposed for debug.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: state=IDLE, busy=0, done=0, f=0, f_mid=1, gt_mid=0, cnt=0, operand registers=0.
- FSM states and transitions:
  - IDLE: if start=1, capture a and b, set cnt=WIDTH-1, eq_mid=1, gt_mid=0, then go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: process bit i=cnt.
    - If eq_mid=1: gt_mid <= a_r[i] & ~b_r[i]; eq_mid <= ~(a_r[i] ^ b_r[i]).
    - If eq_mid=0: gt_mid and eq_mid hold (decision already made).
    - If cnt==0, go to FINAL; else cnt <= cnt-1.
  - FINAL: f <= gt_mid; done <= 1; go to IDLE.
- done is high exactly one cycle and is deasserted on every other cycle.
- Latency: start is sampled at edge 0; done and f are visible after edge WIDTH+1. For WIDTH=8 that is 9 cycles.
- A==B: eq_mid stays 1 through all bits and f=0. f_mid=1 at FINAL.
- start while busy=1 is ignored. No queuing, and the operands are not re-sampled.
- start=1 in the same cycle done=1 is accepted, because the state is already IDLE. This allows back-to-back operations at a WIDTH+2 cycle period.
- Operand inputs may change freely after the accepting edge without affecting the result.
- rst=1 at any time, including mid-SHIFT, returns all registers to their reset values on that edge. No done is produced for the aborted operation.
- WIDTH=1: exactly one SHIFT cycle, latency 2.
- cnt width is clog2(WIDTH), minimum 1 bit. cnt never underflows because the exit check is cnt==0.

Optional Feature:
- Macro: SERIAL_CELL_EARLY_EXIT_EN.
- Defined: in SHIFT, if this cycle's bit differs (a_r[i]^b_r[i]=1), go to FINAL next regardless of cnt.
  - Latency = k+2, where k is the number of equal leading MSBs (0 ≤ k ≤ WIDTH-1).
  - A==B still takes WIDTH+1.
- Undefined: always a full WIDTH SHIFT cycles; latency is fixed at WIDTH+1. Results are identical in both builds.

Test Plan:
- WIDTH=8, a=8'hA5, b=8'h5A, start pulse → f=1, done pulse 9 cycles after start. With EARLY_EXIT_EN, done after 2 cycles.
- a=8'h3C, b=8'h3C → f=0, f_mid=1 at FINAL, done after 9 cycles in both builds.
- a=8'h80, b=8'h81 → f=0. With EARLY_EXIT_EN the latency is 9, because the difference is at the LSB and k=7.
- Start at 8'hFF vs 8'h00, then pulse start again plus change a/b at cycles 3 and 5 → single done at cycle 9, f=1, second start ignored.
- Assert rst at cycle 4 of an operation → busy=0, f=0, done=0 next cycle, no done afterwards. A new start then completes normally.
- Hold start=1 continuously with a=8'h01, b=8'h00 → done pulses every 10 cycles, f=1 each time. busy drops only during each done/IDLE cycle.
